xor_cipher_ctrl: RTL and testbench
==================================

XOR_CIPHER_CTRL -- requirements
Module: xor_cipher_ctrl

Interface
REQ-001 Parameter CFG_W, default 64: serial configuration chain length in bits, {seed[31:0], taps[31:0]}, taps in the LSBs.
REQ-002 Parameter CNT_W, default 16: width of the run-length counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cfg_en  in  1  shift enable for the configuration chain.
REQ-006 cfg_i  in  1  configuration serial data in.
REQ-007 cfg_o  out  1  configuration serial data out; equals shift register MSB, for daisy-chaining.
REQ-008 start  in  1  single-cycle request to begin a keystream session.
REQ-009 len  in  CNT_W  number of keystream bits per session; sampled when start is accepted.
REQ-010 abort  in  1  terminates a running session.
REQ-011 seed  out  32  committed LFSR seed.
REQ-012 taps  out  32  committed LFSR tap mask.
REQ-013 lfsr_load  out  1  one-cycle pulse that loads seed into the LFSR.
REQ-014 ks_en  out  1  keystream advance enable; high for exactly one cycle per emitted bit.
REQ-015 busy  out  1  high in LOAD and RUN.
REQ-016 done  out  1  one-cycle pulse on normal session completion.
REQ-017 cfg_err  out  1  configuration integrity error flag; see REQ-032.

Function
REQ-018 The FSM SHALL have the states IDLE, SHIFT, COMMIT, LOAD, RUN and DONE.
REQ-019 IDLE with cfg_en=1 SHALL go to SHIFT; cfg_en beats start when both are asserted in the same cycle.
REQ-020 In SHIFT, each cycle with cfg_en=1 SHALL perform sr <= {sr[CFG_W-2:0], cfg_i}; cfg_en=0 SHALL go to COMMIT.
REQ-021 COMMIT SHALL copy sr into seed/taps for one cycle, then go to IDLE.
REQ-022 If the committed seed is all-zero, seed SHALL be forced to 32'h1 to avoid LFSR lockup.
REQ-023 IDLE with start=1 and cfg_en=0 SHALL latch len, go to LOAD and assert lfsr_load for one cycle; the next state is RUN.
REQ-024 RUN SHALL assert ks_en every cycle and decrement the counter.
REQ-025 RUN SHALL go to DONE in the cycle after the len-th ks_en pulse.
REQ-026 Latency: from start accepted to the first ks_en is 2 cycles.
REQ-027 len=0: LOAD SHALL go directly to DONE with zero ks_en pulses.
REQ-028 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-029 abort in LOAD or RUN SHALL go to IDLE next cycle; ks_en drops that cycle and done is not pulsed.
REQ-030 start and cfg_en SHALL be ignored outside IDLE (no shift, no requeue); seed/taps remain stable outside COMMIT.
REQ-031 len=2^CNT_W-1 SHALL run fully with no counter wrap.

Configuration
REQ-032 With XOR_CIPHER_CTRL_PARITY_EN defined:
- the chain is CFG_W+1 bits, the extra LSB being even parity over the payload;
- a parity mismatch in COMMIT SHALL keep the old seed/taps and set cfg_err;
- start is ignored while cfg_err=1;
- cfg_err is cleared by the next good commit.
REQ-033 Without XOR_CIPHER_CTRL_PARITY_EN, the chain is CFG_W bits and cfg_err SHALL be tied to 0.

Reset
REQ-034 rst=0 SHALL asynchronously force: state IDLE, sr=0, seed=32'h1, taps=32'h60, counter=0, and cfg_o, lfsr_load, ks_en, busy, done, cfg_err all 0.
REQ-035 Reset in mid-session or mid-shift SHALL discard partial state; after release the block SHALL behave as after power-up.

Structure
REQ-036 Package xor_cipher_pkg SHALL hold:
- the state enum;
- CFG_W and CNT_W defaults;
- DEFAULT_TAPS=32'h60 and DEFAULT_SEED=32'h1.
REQ-037 The shift register plus parity check SHALL be the sub-module xor_cipher_cfg_sr; the FSM and counter SHALL remain in xor_cipher_ctrl.

Verification
REQ-038 Reset release then start with len=4 -> lfsr_load at cycle+1, ks_en high for cycles +2..+5, done at +6, seed=1, taps=32'h60.
REQ-039 Shift 64 bits encoding seed=32'hACE1, taps=32'hB4, then start with len=3 -> seed/taps update after COMMIT and exactly 3 ks_en pulses occur.
REQ-040 Shift an all-zero seed -> seed reads 32'h1 after commit.
REQ-041 start with len=0 -> one lfsr_load pulse, zero ks_en pulses, done 2 cycles after start.
REQ-042 start with len=100, abort on the 10th ks_en -> exactly 10 ks_en pulses, no done, busy=0 next cycle, and a subsequent start works.
REQ-043 Parity build, one flipped bit shifted in -> cfg_err=1, seed/taps unchanged, start ignored; a correct reshift clears cfg_err.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// Shared state encoding, default widths and reset values for the XOR cipher controller.
package xor_cipher_pkg;

  localparam int CFG_W_DEFAULT = 64;
  localparam int CNT_W_DEFAULT = 16;

  localparam logic [31:0] DEFAULT_TAPS = 32'h60;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    COMMIT,
    LOAD,
    RUN,
    DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by the default seed.
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/xor_cipher_cfg_sr.sv
// Serial configuration shift register with optional even-parity integrity check.
// Optional build macro: XOR_CIPHER_CTRL_PARITY_EN adds a parity bit as the chain LSB.
module xor_cipher_cfg_sr
  import xor_cipher_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             cfg_i,
  output logic             cfg_o,
  output logic [CFG_W-1:0] payload,
  output logic             parity_ok
);

`ifdef XOR_CIPHER_CTRL_PARITY_EN
  localparam int SR_W = CFG_W + 1;
`else
  localparam int SR_W = CFG_W;
`endif

  logic [SR_W-1:0] sr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg <= '0;
    end else if (shift_en) begin
      sr_reg <= {sr_reg[SR_W-2:0], cfg_i};
    end
  end

  assign cfg_o = sr_reg[SR_W-1];

`ifdef XOR_CIPHER_CTRL_PARITY_EN
  // Payload plus its parity bit must have an even number of ones.
  assign payload   = sr_reg[SR_W-1:1];
  assign parity_ok = ~^sr_reg;
`else
  assign payload   = sr_reg;
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/xor_cipher_ctrl.sv
// Keystream session controller: config chain commit, LFSR load and run-length sequencing.
// Optional build macro: XOR_CIPHER_CTRL_PARITY_EN (parity-protected configuration chain).
module xor_cipher_ctrl
  import xor_cipher_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_i,
  output logic             cfg_o,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic [31:0]      seed,
  output logic [31:0]      taps,
  output logic             lfsr_load,
  output logic             ks_en,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      seed_reg, taps_reg;
  logic [CFG_W-1:0] payload;
  logic             parity_ok;
  logic             shift_en;
  logic             start_ok;
  logic             commit_ok;

  // The chain only moves while the controller is idle or already shifting.
  assign shift_en  = cfg_en && ((state_reg == IDLE) || (state_reg == SHIFT));
  assign start_ok  = start && !cfg_en && !cfg_err;
  assign commit_ok = (state_reg == COMMIT) && parity_ok;

  xor_cipher_cfg_sr #(
    .CFG_W(CFG_W)
  ) u_cfg_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .cfg_i    (cfg_i),
    .cfg_o    (cfg_o),
    .payload  (payload),
    .parity_ok(parity_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lfsr_load  = 1'b0;
    ks_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_en) begin
          state_next = SHIFT;
        end else if (start_ok) begin
          cnt_next   = len;
          state_next = LOAD;
        end
      end
      SHIFT: begin
        if (!cfg_en) state_next = COMMIT;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      LOAD: begin
        busy      = 1'b1;
        lfsr_load = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          // Counter holds the bits still to emit, including this cycle's.
          ks_en    = 1'b1;
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_reg <= DEFAULT_SEED;
      taps_reg <= DEFAULT_TAPS;
    end else if (commit_ok) begin
      seed_reg <= fix_seed(payload[63:32]);
      taps_reg <= payload[31:0];
    end
  end

  assign seed = seed_reg;
  assign taps = taps_reg;

`ifdef XOR_CIPHER_CTRL_PARITY_EN
  logic cfg_err_reg;

  // A bad commit latches the error; the next good commit clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_reg <= 1'b0;
    end else if (state_reg == COMMIT) begin
      cfg_err_reg <= !parity_ok;
    end
  end

  assign cfg_err = cfg_err_reg;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Self-checking bench for xor_cipher_ctrl: session scoreboard plus cycle-exact latency checks.
module tb_xor_cipher_ctrl;

  localparam int CFG_W = 64;
  localparam int CNT_W = 16;
`ifdef XOR_CIPHER_CTRL_PARITY_EN
  localparam int SR_W = CFG_W + 1;
`else
  localparam int SR_W = CFG_W;
`endif

  logic             clk;
  logic             rst;
  logic             cfg_en;
  logic             cfg_i;
  logic             cfg_o;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic [31:0]      seed;
  logic [31:0]      taps;
  logic             lfsr_load;
  logic             ks_en;
  logic             busy;
  logic             done;
  logic             cfg_err;

  xor_cipher_ctrl #(
    .CFG_W(CFG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (cfg_o),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .seed     (seed),
    .taps     (taps),
    .lfsr_load(lfsr_load),
    .ks_en    (ks_en),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pulses;
    bit          done;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_sess = 0;

  // Reference model of the configuration path.
  logic [SR_W-1:0] sr_m;
  logic [31:0]     seed_m;
  logic [31:0]     taps_m;
  logic            err_m;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SR_W-1:0] make_vec(input logic [31:0] s, input logic [31:0] t);
    logic [63:0] pl;
    pl = {s, t};
`ifdef XOR_CIPHER_CTRL_PARITY_EN
    return {pl, ^pl};
`else
    return pl;
`endif
  endfunction

  task automatic model_commit();
    logic [CFG_W-1:0] pl;
    bit               ok;
`ifdef XOR_CIPHER_CTRL_PARITY_EN
    pl = sr_m[SR_W-1:1];
    ok = (^sr_m) == 1'b0;
`else
    pl = sr_m;
    ok = 1'b1;
`endif
    if (ok) begin
      seed_m = (pl[63:32] == 32'h0) ? 32'h1 : pl[63:32];
      taps_m = pl[31:0];
      err_m  = 1'b0;
    end else begin
      err_m = 1'b1;
    end
  endtask

  // Scoreboard: a session ends when busy falls; count ks_en pulses seen while busy.
  int   ks_cnt = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_d = 1'b0;
      ks_cnt = 0;
    end else begin
      if (ks_en) ks_cnt++;
      if (busy_d && !busy) begin
        n_sess++;
        $display("session %0d: ks_en pulses=%0d done=%0b", n_sess, ks_cnt, done);
        if (sb_q.size() == 0) begin
          check_val("unexpected_session", 64'(ks_cnt), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check_val("ks_count", 64'(ks_cnt), 64'(e.pulses));
          check_val("done_seen", 64'(done), 64'(e.done));
        end
        ks_cnt = 0;
      end
      busy_d = busy;
    end
  end

  task automatic shift_cfg(input logic [SR_W-1:0] vec, input bit with_start);
    for (int i = SR_W - 1; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_i  = vec[i];
      start  = with_start && (i == SR_W - 1);
      len    = CNT_W'(7);
      sr_m   = {sr_m[SR_W-2:0], vec[i]};
      tick();
    end
    start  = 1'b0;
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    @(negedge clk);
    check_val("cfg_o", 64'(cfg_o), 64'(sr_m[SR_W-1]));
    check_val("busy_shift", 64'(busy), 64'(0));
    tick();
    @(negedge clk);
    check_val("seed_pre_commit", 64'(seed), 64'(seed_m));
    tick();
    model_commit();
    @(negedge clk);
    check_val("seed_commit", 64'(seed), 64'(seed_m));
    check_val("taps_commit", 64'(taps), 64'(taps_m));
    check_val("cfg_err_commit", 64'(cfg_err), 64'(err_m));
    tick();
  endtask

  // abort_n < 0: run to completion; otherwise abort right after the abort_n-th ks_en.
  task automatic run_session(input int unsigned n, input int abort_n, input bit noise);
    exp_t e;
    int   k;
    int   pulses;
    bit   fin;
    e.pulses = (abort_n < 0) ? n : abort_n;
    e.done   = (abort_n < 0);
    sb_q.push_back(e);
    start = 1'b1;
    len   = CNT_W'(n);
    tick();
    start  = 1'b0;
    k      = 1;
    pulses = 0;
    fin    = 1'b0;
    while (!fin) begin
      if (abort_n >= 0 && pulses == abort_n) abort = 1'b1;
      if (noise && k >= 2 && k <= int'(n) + 2) begin
        cfg_en = 1'b1;
        cfg_i  = 1'b1;
        start  = 1'b1;
      end
      @(negedge clk);
      if (n <= 8 && abort_n < 0) begin
        check_val("lfsr_load", 64'(lfsr_load), 64'(k == 1));
        check_val("ks_en", 64'(ks_en), 64'(k >= 2 && k <= int'(n) + 1));
        check_val("busy", 64'(busy), 64'(k <= int'(n) + 1));
        check_val("done", 64'(done), 64'(k == int'(n) + 2));
      end
      if (ks_en) pulses++;
      cfg_en = 1'b0;
      cfg_i  = 1'b0;
      start  = 1'b0;
      if (abort) begin
        check_val("ks_en_on_abort", 64'(ks_en), 64'(0));
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_val("busy_after_abort", 64'(busy), 64'(0));
        check_val("done_after_abort", 64'(done), 64'(0));
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end else if (k > int'(n) + 10) begin
        check_val("session_timeout", 64'(k), 64'(n + 2));
        fin = 1'b1;
      end else begin
        tick();
        k++;
      end
    end
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    start  = 1'b0;
    len    = '0;
    abort  = 1'b0;
    sr_m   = '0;
    seed_m = 32'h1;
    taps_m = 32'h60;
    err_m  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_seed", 64'(seed), 64'(32'h1));
    check_val("rst_taps", 64'(taps), 64'(32'h60));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_ks_en", 64'(ks_en), 64'(0));
    check_val("rst_lfsr_load", 64'(lfsr_load), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_cfg_o", 64'(cfg_o), 64'(0));
    check_val("rst_cfg_err", 64'(cfg_err), 64'(0));

    @(posedge clk);
    #1;
    rst = 1'b1;

    run_session(4, -1, 1'b0);
    check_val("seed_default", 64'(seed), 64'(seed_m));
    check_val("taps_default", 64'(taps), 64'(taps_m));

    shift_cfg(make_vec(32'hACE1, 32'hB4), 1'b0);
    run_session(3, -1, 1'b0);

    shift_cfg(make_vec(32'h0, 32'h1234), 1'b0);
    check_val("zero_seed_forced", 64'(seed), 64'(32'h1));

    run_session(0, -1, 1'b0);

    run_session(100, 10, 1'b0);
    run_session(5, -1, 1'b0);

    // Config and start activity during a session must be ignored.
    run_session(6, -1, 1'b1);
    @(negedge clk);
    check_val("noise_cfg_o", 64'(cfg_o), 64'(sr_m[SR_W-1]));
    check_val("noise_seed", 64'(seed), 64'(seed_m));
    check_val("noise_taps", 64'(taps), 64'(taps_m));
    tick();

    // cfg_en and start together in IDLE: the shift wins.
    shift_cfg(make_vec(32'h1357_9BDF, 32'h8000_0057), 1'b1);

`ifdef XOR_CIPHER_CTRL_PARITY_EN
    begin
      logic [SR_W-1:0] bad;
      bad     = make_vec(32'hDEAD_BEEF, 32'hC5);
      bad[17] = ~bad[17];
      shift_cfg(bad, 1'b0);
      check_val("parity_err_set", 64'(cfg_err), 64'(1));
      start = 1'b1;
      len   = CNT_W'(5);
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_val("start_blocked_busy", 64'(busy), 64'(0));
        check_val("start_blocked_load", 64'(lfsr_load), 64'(0));
        tick();
      end
      shift_cfg(make_vec(32'hDEAD_BEEF, 32'hC5), 1'b0);
      check_val("parity_err_clear", 64'(cfg_err), 64'(0));
      run_session(2, -1, 1'b0);
    end
`endif

    // Reset in the middle of a session (no scoreboard entry: it never completes).
    start = 1'b1;
    len   = CNT_W'(20);
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    sr_m   = '0;
    seed_m = 32'h1;
    taps_m = 32'h60;
    err_m  = 1'b0;
    check_val("mid_rst_busy", 64'(busy), 64'(0));
    check_val("mid_rst_ks_en", 64'(ks_en), 64'(0));
    check_val("mid_rst_seed", 64'(seed), 64'(seed_m));
    check_val("mid_rst_taps", 64'(taps), 64'(taps_m));
    check_val("mid_rst_cfg_o", 64'(cfg_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_session(4, -1, 1'b0);

    // Longest session: no counter wrap.
    run_session(32'(2 ** CNT_W - 1), -1, 1'b0);

    check_val("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
